// File: rtl/toy_pack.sv
// Shared types and widths for the toy fetch front end.
package toy_pack;

  localparam int ADDR_WIDTH          = 32;
  localparam int FETCH_WRITE_CHANNEL = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_HALT
  } fetch_ctrl_state_e;

endpackage

// File: rtl/toy_fetch_ost_cnt.sv
// Outstanding memory request counter.
// Up on fire, down on response; flags underflow.
module toy_fetch_ost_cnt #(
  parameter int MAX = 4,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         full,
  output logic         err
);

  logic empty;

  assign full  = (cnt == W'(MAX));
  assign empty = (cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      err <= 1'b0;
    end else begin
      // a response with nothing outstanding is sticky until reset
      if (dec && empty)
        err <= 1'b1;
      unique case ({inc, dec})
        2'b10: if (!full) cnt <= cnt + 1'b1;
        2'b01: if (!empty) cnt <= cnt - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/toy_fetch_req_ctrl.sv
// Fetch request sequencer: owns the fetch PC, issues
// block requests and epoch-tags them across redirects.
module toy_fetch_req_ctrl
  import toy_pack::*;
#(
  parameter int BLK_BYTES = 4 * FETCH_WRITE_CHANNEL,
  parameter int MAX_OST   = 4,
  parameter int OW        = $clog2(MAX_OST + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  redirect_vld,
  input  logic [ADDR_WIDTH-1:0] redirect_addr,
  input  logic                  halt,
  input  logic                  credit_ok,
  output logic                  credit_clear,
  output logic [ADDR_WIDTH-1:0] credit_fetch_addr,
  output logic                  mem_req_vld,
  input  logic                  mem_req_rdy,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  output logic                  mem_req_epoch,
  input  logic                  mem_rsp_vld,
  input  logic                  mem_rsp_epoch,
  output logic                  mem_rsp_rdy,
  output logic                  rsp_keep,
  output logic [OW-1:0]         ost_cnt,
  output logic                  err
);

  localparam logic [ADDR_WIDTH-1:0] BLK_INC =
    ADDR_WIDTH'(BLK_BYTES);
  localparam logic [ADDR_WIDTH-1:0] BLK_MASK =
    ~(BLK_INC - 1'b1);

  fetch_ctrl_state_e       state;
  logic [ADDR_WIDTH-1:0] pc;
  logic                  epoch;
  logic [ADDR_WIDTH-1:0] epc;
  logic [ADDR_WIDTH-1:0] blk_addr;
  logic                  ost_full;
  logic                  req_fire;
  logic                  active;

  assign epc      = redirect_vld ? redirect_addr : pc;
  assign blk_addr = epc & BLK_MASK;

  assign credit_clear      = redirect_vld;
  assign credit_fetch_addr = epc;
  assign mem_req_addr      = blk_addr;
  assign mem_req_epoch     = epoch ^ redirect_vld;
  assign mem_rsp_rdy       = 1'b1;

  // a redirect out of IDLE issues its first block immediately
  assign active      = (state == ST_RUN) | redirect_vld;
  assign mem_req_vld = active & ~halt
                     & (credit_ok | redirect_vld)
                     & ~ost_full;
  assign req_fire    = mem_req_vld & mem_req_rdy;

  assign rsp_keep = mem_rsp_vld & (mem_rsp_epoch == epoch);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      pc    <= '0;
      epoch <= 1'b0;
    end else begin
      if (req_fire)
        pc <= blk_addr + BLK_INC;
      else if (redirect_vld)
        pc <= redirect_addr;
      if (redirect_vld)
        epoch <= ~epoch;
      if (redirect_vld || state != ST_IDLE)
        state <= halt ? ST_HALT : ST_RUN;
    end
  end

  toy_fetch_ost_cnt #(
    .MAX (MAX_OST),
    .W   (OW)
  ) u_ost (
    .clk  (clk),
    .rst  (rst),
    .inc  (req_fire),
    .dec  (mem_rsp_vld),
    .cnt  (ost_cnt),
    .full (ost_full),
    .err  (err)
  );

endmodule

// File: tb/tb_toy_fetch_req_ctrl.sv
// Scoreboard bench for toy_fetch_req_ctrl: a block-level
// model predicts each cycle, a monitor compares at negedge.
module tb_toy_fetch_req_ctrl;

  localparam int AW  = 32;
  localparam int BLK = 16;
  localparam int MO  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          redirect_vld;
  logic [AW-1:0] redirect_addr;
  logic          halt;
  logic          credit_ok;
  logic          credit_clear;
  logic [AW-1:0] credit_fetch_addr;
  logic          mem_req_vld;
  logic          mem_req_rdy;
  logic [AW-1:0] mem_req_addr;
  logic          mem_req_epoch;
  logic          mem_rsp_vld;
  logic          mem_rsp_epoch;
  logic          mem_rsp_rdy;
  logic          rsp_keep;
  logic [2:0]    ost_cnt;
  logic          err;

  toy_fetch_req_ctrl #(.BLK_BYTES(BLK), .MAX_OST(MO)) dut (
    .clk               (clk),
    .rst               (rst),
    .redirect_vld      (redirect_vld),
    .redirect_addr     (redirect_addr),
    .halt              (halt),
    .credit_ok         (credit_ok),
    .credit_clear      (credit_clear),
    .credit_fetch_addr (credit_fetch_addr),
    .mem_req_vld       (mem_req_vld),
    .mem_req_rdy       (mem_req_rdy),
    .mem_req_addr      (mem_req_addr),
    .mem_req_epoch     (mem_req_epoch),
    .mem_rsp_vld       (mem_rsp_vld),
    .mem_rsp_epoch     (mem_rsp_epoch),
    .mem_rsp_rdy       (mem_rsp_rdy),
    .rsp_keep          (rsp_keep),
    .ost_cnt           (ost_cnt),
    .err               (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          vld;
    logic [AW-1:0] addr;
    logic          ep;
    logic          clr;
    logic [AW-1:0] cfa;
    logic          keep;
    int            ost;
    logic          err;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // reference model: fetch mode, pc, epoch and in-flight epochs
  int            m_mode;
  logic [AW-1:0] m_pc;
  logic          m_ep;
  logic          m_err;
  logic          m_q[$];

  task automatic model_reset();
    m_mode = 0;
    m_pc   = '0;
    m_ep   = 1'b0;
    m_err  = 1'b0;
    m_q.delete();
  endtask

  task automatic chk(input string nm,
                     input logic [AW-1:0] act,
                     input logic [AW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("req_vld", AW'(mem_req_vld), AW'(e.vld));
      if (e.vld) begin
        chk("req_addr", mem_req_addr, e.addr);
        chk("req_epoch", AW'(mem_req_epoch), AW'(e.ep));
      end
      chk("credit_clear", AW'(credit_clear), AW'(e.clr));
      chk("credit_addr", credit_fetch_addr, e.cfa);
      chk("rsp_keep", AW'(rsp_keep), AW'(e.keep));
      chk("ost_cnt", AW'(ost_cnt), AW'(e.ost));
      chk("err", AW'(err), AW'(e.err));
      chk("rsp_rdy", AW'(mem_rsp_rdy), AW'(1));
    end
  end

  // one clock of stimulus: drive, predict, advance model
  task automatic cyc(input logic rv, input logic [AW-1:0] ra,
                     input logic h, input logic cok,
                     input logic rdy, input logic rsp);
    exp_t          e;
    logic [AW-1:0] epc;
    logic          rep;
    logic          fire;
    @(posedge clk);
    #1;
    rep = (m_q.size() > 0) ? m_q[0] : 1'b0;
    redirect_vld  = rv;
    redirect_addr = ra;
    halt          = h;
    credit_ok     = cok;
    mem_req_rdy   = rdy;
    mem_rsp_vld   = rsp;
    mem_rsp_epoch = rep;
    epc    = rv ? ra : m_pc;
    e.vld  = (m_mode == 1 || rv) && !h && (cok || rv)
             && (m_q.size() < MO);
    e.addr = epc - (epc % BLK);
    e.ep   = m_ep ^ rv;
    e.clr  = rv;
    e.cfa  = epc;
    e.keep = rsp && (rep == m_ep);
    e.ost  = m_q.size();
    e.err  = m_err;
    exp_q.push_back(e);
    fire = e.vld && rdy;
    if (rsp) begin
      if (m_q.size() > 0) void'(m_q.pop_front());
      else m_err = 1'b1;
    end
    if (fire) m_q.push_back(e.ep);
    if (fire) m_pc = e.addr + BLK;
    else if (rv) m_pc = ra;
    m_ep = e.ep;
    if (rv || m_mode != 0) m_mode = h ? 2 : 1;
  endtask

  task automatic reset_cyc();
    exp_t e;
    @(posedge clk);
    #1;
    rst = 1'b1;
    redirect_vld = 0; redirect_addr = '0; halt = 0;
    credit_ok = 0; mem_req_rdy = 0; mem_rsp_vld = 0;
    mem_rsp_epoch = 0;
    model_reset();
    e.vld = 0; e.addr = '0; e.ep = 0; e.clr = 0;
    e.cfa = '0; e.keep = 0; e.ost = 0; e.err = 0;
    exp_q.push_back(e);
  endtask

  task automatic drain();
    int n = 0;
    while (m_q.size() > 0 && n < 20) begin
      cyc(0, '0, 1, 0, 0, 1);
      n++;
    end
  endtask

  initial begin
    logic h_r;
    rst = 1'b1;
    redirect_vld = 0; redirect_addr = '0; halt = 0;
    credit_ok = 0; mem_req_rdy = 0; mem_rsp_vld = 0;
    mem_rsp_epoch = 0;
    model_reset();
    repeat (3) reset_cyc();
    @(posedge clk); #1; rst = 1'b0;

    // first fetch in the redirect cycle, then streaming
    cyc(1, 32'h1006, 0, 1, 1, 0);
    cyc(0, '0, 0, 1, 1, 0);
    cyc(0, '0, 0, 1, 0, 0);
    cyc(0, '0, 0, 1, 0, 0);
    cyc(0, '0, 0, 1, 0, 0);
    cyc(0, '0, 0, 1, 1, 0);
    // full: no request, even with a response that cycle
    cyc(0, '0, 0, 1, 1, 0);
    cyc(0, '0, 0, 1, 1, 1);
    cyc(0, '0, 0, 1, 1, 0);
    cyc(0, '0, 0, 0, 0, 1);
    cyc(0, '0, 0, 0, 0, 1);
    // redirect with old responses in flight
    cyc(1, 32'h2000, 0, 0, 1, 0);
    cyc(0, '0, 0, 0, 0, 1);
    cyc(0, '0, 0, 0, 0, 1);
    cyc(0, '0, 0, 0, 0, 1);
    // halt, redirect while halted, resume
    cyc(0, '0, 1, 1, 1, 0);
    cyc(0, '0, 1, 1, 1, 0);
    cyc(1, 32'h3008, 1, 1, 1, 0);
    cyc(0, '0, 0, 1, 1, 0);
    drain();
    // pc wrap at the top of the address space
    cyc(1, 32'hFFFF_FFF2, 0, 1, 1, 0);
    cyc(0, '0, 0, 1, 1, 0);
    drain();
    // underflow sets a sticky error
    cyc(0, '0, 1, 0, 0, 1);
    cyc(0, '0, 1, 0, 0, 0);
    cyc(0, '0, 0, 1, 1, 0);

    h_r = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      logic          rv, cok, rdy, rsp;
      logic [AW-1:0] ra;
      if (i == 700) begin
        reset_cyc();
        @(posedge clk); #1; rst = 1'b0;
      end
      if ($urandom_range(19) == 0) h_r = ~h_r;
      rv  = ($urandom_range(15) == 0);
      ra  = ($urandom_range(7) == 0)
            ? (32'hFFFF_FFE0 | ($urandom & 32'h1E))
            : ($urandom & 32'hFFFF_FFFE);
      cok = ($urandom_range(3) != 0);
      rdy = ($urandom_range(3) != 0);
      rsp = (m_q.size() > 0) && ($urandom_range(4) < 2);
      cyc(rv, ra, h_r, cok, rdy, rsp);
    end

    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d expected=0",
               exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
